// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the decode stage.
//   - forward-select encodings for the A/B operand muxes
//   - bit positions inside the 5-bit decode control bundle
//   - load-use hazard FSM state type and its counter width
package pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_ALU = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   // signals = {SRC1, SRC2, RegDst, ExtOp, ExtPlace}
   localparam int SIG_SRC1     = 4;
   localparam int SIG_SRC2     = 3;
   localparam int SIG_REGDST   = 2;
   localparam int SIG_EXTOP    = 1;
   localparam int SIG_EXTPLACE = 0;

   localparam int CNT_W = 3;

   typedef enum logic {
      HZ_IDLE   = 1'b0,
      HZ_BUBBLE = 1'b1
   } hz_state_t;

endpackage

// File: rtl/regfile_wt.sv
// regfile_wt: NREGS x DATA_W register file, one write port, two operand read
// ports plus a dedicated read of the link register.
//   clk, reset        : clock, asynchronous active-high clear of every entry
//   we, wa, wd        : synchronous write (ignored for address 0)
//   ra1/rd1, ra2/rd2  : combinational operand reads
//   ra3/rd3           : combinational link-register read
// Reads are write-through: reading the address being written this cycle
// returns the write data. Address 0 always reads zero.
module regfile_wt
   import pipe_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NREGS  = 8,
   localparam int AW    = $clog2(NREGS)
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [AW-1:0]     wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [AW-1:0]     ra1,
   input  logic [AW-1:0]     ra2,
   input  logic [AW-1:0]     ra3,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic [DATA_W-1:0] rd3
);

   logic [DATA_W-1:0] mem [NREGS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      end else if (we && (wa != '0)) begin
         mem[wa] <= wd;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] a);
      if (a == '0)            return '0;
      else if (we && wa == a) return wd;
      else                    return mem[a];
   endfunction

   always_comb begin
      rd1 = read_port(ra1);
      rd2 = read_port(ra2);
      rd3 = read_port(ra3);
   end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage with integrated ID/EX register.
//   Inputs : instr/pc_id/valid_in from IF/ID, decode controls (signals),
//            forward selects and forward values, writeback port, EX load info,
//            downstream stall_in and flush.
//   Outputs: stall_out (combinational, freezes PC and IF/ID) and the registered
//            ID/EX entry: valid_q, a_q, b_q, imm_q, br_tgt_q, jmp_tgt_q, ret_q,
//            rd_q and the signed compare flags gt_q/lt_q/eq_q.
module id_stage_pipe
   import pipe_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int NREGS    = 8,
   parameter int LOAD_LAT = 1,
   localparam int AW      = $clog2(NREGS)
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [15:0]       instr,
   input  logic [15:0]       pc_id,
   input  logic [4:0]        signals,
   input  logic [1:0]        fwd_a,
   input  logic [1:0]        fwd_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] mem_result,
   input  logic              wb_en,
   input  logic [AW-1:0]     wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ex_load,
   input  logic [AW-1:0]     ex_rd,
   input  logic              stall_in,
   input  logic              flush,
   output logic              stall_out,
   output logic              valid_q,
   output logic [DATA_W-1:0] a_q,
   output logic [DATA_W-1:0] b_q,
   output logic [DATA_W-1:0] imm_q,
   output logic [15:0]       br_tgt_q,
   output logic [15:0]       jmp_tgt_q,
   output logic [DATA_W-1:0] ret_q,
   output logic [AW-1:0]     rd_q,
   output logic              gt_q,
   output logic              lt_q,
   output logic              eq_q
);

   localparam logic [AW-1:0] LINK = AW'(NREGS - 1);

   // 3-bit instruction register fields, truncated or zero-padded to AW bits
   function automatic logic [AW-1:0] fit_addr(input logic [2:0] f);
      logic [AW+2:0] t;
      t = {{AW{1'b0}}, f};
      return t[AW-1:0];
   endfunction

   // Byte immediate: low or high placement, then optional sign extension
   function automatic logic [DATA_W-1:0] ext_imm(input logic [7:0] byte_v,
                                                 input logic ext_op,
                                                 input logic ext_place);
      logic [15:0]       h;
      logic [DATA_W-1:0] r;
      h = ext_place ? {byte_v, 8'h00} : {{8{ext_op & byte_v[7]}}, byte_v};
      r = {DATA_W{ext_op & h[15]}};
      r[15:0] = h;
      return r;
   endfunction

   logic src1, src2, reg_dst, ext_op, ext_place;
   assign src1      = signals[SIG_SRC1];
   assign src2      = signals[SIG_SRC2];
   assign reg_dst   = signals[SIG_REGDST];
   assign ext_op    = signals[SIG_EXTOP];
   assign ext_place = signals[SIG_EXTPLACE];

   // Opcode nibble is decoded upstream; only the jump target uses instr[11:0]
   logic unused_opcode;
   assign unused_opcode = ^instr[15:12];

   logic [AW-1:0] ra, rb, rd;
   assign ra = src1 ? '0 : fit_addr(instr[8:6]);
   assign rb = src2 ? fit_addr(instr[5:3]) : fit_addr(instr[11:9]);
   assign rd = reg_dst ? LINK : fit_addr(instr[11:9]);

   logic [DATA_W-1:0] rf_a, rf_b, rf_link;

   regfile_wt #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
      .clk   (clk),
      .reset (reset),
      .we    (wb_en),
      .wa    (wb_rd),
      .wd    (wb_data),
      .ra1   (ra),
      .ra2   (rb),
      .ra3   (LINK),
      .rd1   (rf_a),
      .rd2   (rf_b),
      .rd3   (rf_link)
   );

   logic signed [DATA_W-1:0] a_fwd, b_fwd;

   always_comb begin
      case (fwd_a)
         FWD_ALU: a_fwd = alu_result;
         FWD_MEM: a_fwd = mem_result;
         FWD_WB:  a_fwd = wb_data;
         default: a_fwd = rf_a;
      endcase
      case (fwd_b)
         FWD_ALU: b_fwd = alu_result;
         FWD_MEM: b_fwd = mem_result;
         FWD_WB:  b_fwd = wb_data;
         default: b_fwd = rf_b;
      endcase
   end

   logic [DATA_W-1:0] imm_id;
   logic [15:0]       br_id;
   assign imm_id = ext_imm(instr[7:0], ext_op, ext_place);
   assign br_id  = imm_id[15:0] + pc_id - 16'd1;

   // Load-use hazard: the detecting cycle is the first stall cycle, BUBBLE
   // supplies the remaining LOAD_LAT-1, so LOAD_LAT=1 never leaves IDLE.
   hz_state_t        hz_state;
   logic [CNT_W-1:0] hz_cnt;
   logic             hz_detect, hz_stall;

   assign hz_detect = (hz_state == HZ_IDLE) && valid_in && ex_load && (ex_rd != '0) &&
                      ((!src1 && ex_rd == ra) || ex_rd == rb);
   assign hz_stall  = hz_detect || (hz_state == HZ_BUBBLE);
   assign stall_out = hz_stall || stall_in;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hz_state <= HZ_IDLE;
         hz_cnt   <= '0;
      end else if (flush) begin
         hz_state <= HZ_IDLE;
         hz_cnt   <= '0;
      end else if (!stall_in) begin
         case (hz_state)
            HZ_IDLE: begin
               if (hz_detect && LOAD_LAT > 1) begin
                  hz_state <= HZ_BUBBLE;
                  hz_cnt   <= CNT_W'(LOAD_LAT - 1);
               end
            end
            default: begin
               if (hz_cnt <= CNT_W'(1)) begin
                  hz_state <= HZ_IDLE;
                  hz_cnt   <= '0;
               end else begin
                  hz_cnt <= hz_cnt - CNT_W'(1);
               end
            end
         endcase
      end
   end

   // ---- ID / EX boundary ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         imm_q     <= '0;
         br_tgt_q  <= '0;
         jmp_tgt_q <= '0;
         ret_q     <= '0;
         rd_q      <= '0;
         gt_q      <= 1'b0;
         lt_q      <= 1'b0;
         eq_q      <= 1'b0;
      end else if (flush || !stall_in) begin
         // Bubbles and flushes still load data; only valid_q carries meaning
         valid_q   <= valid_in && !hz_stall && !flush;
         a_q       <= a_fwd;
         b_q       <= b_fwd;
         imm_q     <= imm_id;
         br_tgt_q  <= br_id;
         jmp_tgt_q <= {pc_id[15:12], instr[11:0]};
         ret_q     <= rf_link;
         rd_q      <= rd;
         gt_q      <= a_fwd > b_fwd;
         lt_q      <= a_fwd < b_fwd;
         eq_q      <= a_fwd == b_fwd;
      end
   end

endmodule
